// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter with burst locking in front of a circular FIFO whose occupancy it tracks.
// Optional per-requester saturating grant counters are built when FIFO_ARB_GRANT_CNT_EN is defined.
module fifo_push_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]            gnt,
    input  logic                       pop_in,
    output logic                       fifo_push,
    output logic [WIDTH-1:0]           fifo_data,
    output logic                       fifo_pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
`ifdef FIFO_ARB_GRANT_CNT_EN
    output logic [NREQ*8-1:0]          gnt_cnt,
`endif
    output logic                       dbg_state
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(BURST+1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // Handshake: a word moves on any cycle where req[i] and gnt[i] are both high; gnt is
    // combinational and never asserted toward a requester whose req is low.

    logic [0:0]    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] beats_q, beats_d;
    logic [CW-1:0] count_q, count_d;

    logic          rr_found;
    logic [OW-1:0] rr_pick;
    logic [OW-1:0] rr_cand;
    logic          gnt_valid;
    logic [OW-1:0] gnt_idx;
    logic [BW-1:0] beats_inc;

    function automatic logic [OW-1:0] ptr_after(input logic [OW-1:0] p);
        if (int'(p) == NREQ - 1) begin
            return '0;
        end
        return p + OW'(1);
    endfunction

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign dbg_state = state_q;

    // Circular search for the first requester at or after the round-robin pointer.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_cand = OW'((int'(rr_ptr_q) + k) % NREQ);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        beats_d   = beats_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        beats_inc = beats_q + BW'(1);
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (!full && rr_found) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = rr_pick;
                        if (BURST == 1) begin
                            rr_ptr_d = ptr_after(rr_pick);
                        end else begin
                            state_d = ST_LOCK;
                            owner_d = rr_pick;
                            beats_d = BW'(1);
                        end
                    end
                end
                ST_LOCK: begin
                    // Owner letting go costs one idle cycle; a full FIFO just stalls the burst.
                    if (!req[owner_q]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = ptr_after(owner_q);
                    end else if (!full) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = owner_q;
                        beats_d   = beats_inc;
                        if (beats_inc == BW'(BURST)) begin
                            state_d  = ST_IDLE;
                            rr_ptr_d = ptr_after(owner_q);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        gnt       = '0;
        fifo_data = '0;
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
            fifo_data    = req_data[gnt_idx*WIDTH +: WIDTH];
        end
    end

    assign fifo_push = gnt_valid;
    assign fifo_pop  = rst & pop_in & ~empty;

    always_comb begin
        count_d = count_q + CW'(fifo_push) - CW'(fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            beats_q  <= BW'(1);
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            beats_q  <= beats_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef FIFO_ARB_GRANT_CNT_EN
    logic [NREQ*8-1:0] gnt_cnt_q, gnt_cnt_d;

    // Each counter sticks at 255 rather than wrapping.
    always_comb begin
        gnt_cnt_d = gnt_cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && (gnt_cnt_q[i*8 +: 8] != 8'hFF)) begin
                gnt_cnt_d[i*8 +: 8] = gnt_cnt_q[i*8 +: 8] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_cnt_q <= '0;
        end else begin
            gnt_cnt_q <= gnt_cnt_d;
        end
    end

    assign gnt_cnt = gnt_cnt_q;
`else
    // Grant counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed vector table, hand sequences, and randomized traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_fifo_push_arbiter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int NREQ  = 4;
    localparam int BURST = 2;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int NVEC  = 27;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  pop_in;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_push;
    logic [WIDTH-1:0]      fifo_data;
    logic                  fifo_pop;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  dbg_state;
`ifdef FIFO_ARB_GRANT_CNT_EN
    logic [NREQ*8-1:0]     gnt_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO contents as a queue, plus the current burst holder (-1 = none).
    logic [WIDTH-1:0] exp_q[$];
    int m_owner;
    int m_beats;
    int m_ptr;
    int m_wait[NREQ];
    int last_g;

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] req;
        logic            pop;
        logic [NREQ-1:0] gnt;
        logic            fpop;
        int              cnt;
        logic            lock;
    } vec_t;
    vec_t tbl[NVEC];

    logic [NREQ-1:0]  nr;
    logic             r_rst;
    logic             r_pop;
    logic [WIDTH-1:0] exp_d;

    fifo_push_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .BURST(BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .pop_in(pop_in),
        .fifo_push(fifo_push),
        .fifo_data(fifo_data),
        .fifo_pop(fifo_pop),
        .count(count),
        .full(full),
        .empty(empty),
`ifdef FIFO_ARB_GRANT_CNT_EN
        .gnt_cnt(gnt_cnt),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the test ended");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick();
        if (!rst || exp_q.size() == DEPTH) return -1;
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive(input logic d_rst, input logic [NREQ-1:0] d_req, input logic d_pop);
        rst    = d_rst;
        req    = d_req;
        pop_in = d_pop;
        #1;
    endtask

    task automatic check_model();
        int g;
        logic [NREQ-1:0]  eg;
        logic [WIDTH-1:0] ed;
        g  = model_pick();
        eg = '0;
        ed = '0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ed    = req_data[g*WIDTH +: WIDTH];
        end
        chk("gnt", gnt, eg);
        chk("fifo_push", fifo_push, g >= 0);
        chk("fifo_data", fifo_data, ed);
        chk("fifo_pop", fifo_pop, rst && pop_in && exp_q.size() > 0);
        chk("count", count, exp_q.size());
        chk("full", full, exp_q.size() == DEPTH);
        chk("empty", empty, exp_q.size() == 0);
        chk("lock_state", dbg_state, m_owner >= 0);
    endtask

    // Advance the model across one rising edge using the inputs in force before it.
    task automatic tick();
        int g;
        logic p;
        logic [NREQ-1:0]       r;
        logic [NREQ*WIDTH-1:0] d;
        g = model_pick();
        p = rst && pop_in && exp_q.size() > 0;
        r = req;
        d = req_data;
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            m_owner = -1;
            m_beats = 0;
            m_ptr   = 0;
            for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
            g = -1;
        end else begin
            if (p) void'(exp_q.pop_front());
            if (g >= 0) exp_q.push_back(d[g*WIDTH +: WIDTH]);
            for (int i = 0; i < NREQ; i++) begin
                if (g == i) begin
                    n_cmp++;
                    if (m_wait[i] > (NREQ-1)*BURST) begin
                        n_bad++;
                        $display("FAIL wait_bound req%0d: waited %0d beats, limit %0d", i, m_wait[i], (NREQ-1)*BURST);
                    end
                    m_wait[i] = 0;
                end else if (r[i] && g >= 0) begin
                    m_wait[i]++;
                end else if (!r[i]) begin
                    m_wait[i] = 0;
                end
            end
            if (m_owner >= 0) begin
                if (!r[m_owner]) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end else if (g >= 0) begin
                    m_beats++;
                    if (m_beats == BURST) begin
                        m_ptr   = (m_owner + 1) % NREQ;
                        m_owner = -1;
                    end
                end
            end else if (g >= 0) begin
                if (BURST == 1) begin
                    m_ptr = (g + 1) % NREQ;
                end else begin
                    m_owner = g;
                    m_beats = 1;
                end
            end
        end
        last_g = g;
        @(negedge clk);
    endtask

    initial begin
        // rst, req, pop | gnt, fifo_pop, count, lock
        tbl[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 0, 1'b0};
        tbl[2]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 1, 1'b1};
        tbl[3]  = '{1'b1, 4'b1111, 1'b0, 4'b0010, 1'b0, 2, 1'b0};
        tbl[4]  = '{1'b1, 4'b1111, 1'b0, 4'b0010, 1'b0, 3, 1'b1};
        tbl[5]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 4, 1'b0};
        tbl[6]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 4, 1'b0};
        tbl[7]  = '{1'b1, 4'b0100, 1'b1, 4'b0000, 1'b1, 4, 1'b0};
        tbl[8]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, 3, 1'b0};
        tbl[9]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 4, 1'b1};
        tbl[10] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 3, 1'b0};
        tbl[11] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2, 1'b0};
        tbl[12] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 1, 1'b0};
        tbl[13] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
        tbl[14] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
        tbl[15] = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0, 0, 1'b0};
        tbl[16] = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 1, 1'b1};
        tbl[17] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, 1, 1'b0};
        tbl[18] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2, 1'b1};
        tbl[19] = '{1'b1, 4'b1011, 1'b0, 4'b0010, 1'b0, 2, 1'b0};
        tbl[20] = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, 3, 1'b1};
        tbl[21] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 3, 1'b0};
        tbl[22] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 1'b0, 3, 1'b1};
        tbl[23] = '{1'b0, 4'b1001, 1'b0, 4'b0000, 1'b0, 0, 1'b0};
        tbl[24] = '{1'b1, 4'b1001, 1'b0, 4'b0001, 1'b0, 0, 1'b0};
        tbl[25] = '{1'b1, 4'b1001, 1'b0, 4'b0001, 1'b0, 1, 1'b1};
        tbl[26] = '{1'b1, 4'b1001, 1'b0, 4'b1000, 1'b0, 2, 1'b0};

        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        m_owner  = -1;
        m_beats  = 0;
        m_ptr    = 0;
        last_g   = -1;
        for (int i = 0; i < NREQ; i++) m_wait[i] = 0;

        // Clock/reset: two reset edges before anything is compared.
        drive(1'b0, '0, 1'b0);
        tick();
        tick();

        // Directed vector table.
        for (int t = 0; t < NVEC; t++) begin
            drive(tbl[t].rst, tbl[t].req, tbl[t].pop);
            exp_d = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (tbl[t].gnt[i]) exp_d = WIDTH'(8'h10 + i);
            end
            chk($sformatf("tbl%0d.gnt", t), gnt, tbl[t].gnt);
            chk($sformatf("tbl%0d.fifo_push", t), fifo_push, |tbl[t].gnt);
            chk($sformatf("tbl%0d.fifo_data", t), fifo_data, exp_d);
            chk($sformatf("tbl%0d.fifo_pop", t), fifo_pop, tbl[t].fpop);
            chk($sformatf("tbl%0d.count", t), count, tbl[t].cnt);
            chk($sformatf("tbl%0d.full", t), full, tbl[t].cnt == DEPTH);
            chk($sformatf("tbl%0d.empty", t), empty, tbl[t].cnt == 0);
            chk($sformatf("tbl%0d.lock", t), dbg_state, tbl[t].lock);
            tick();
        end

        // Hand sequence: a burst owner stalls on a full FIFO and resumes after a pop.
        drive(1'b0, '0, 1'b0);
        tick();
        drive(1'b1, 4'b0010, 1'b0); check_model(); tick();
        drive(1'b1, 4'b0001, 1'b0); check_model(); chk("hs.bubble_gnt", gnt, 4'b0000); tick();
        drive(1'b1, 4'b0001, 1'b0); check_model(); tick();
        drive(1'b1, 4'b0001, 1'b0); check_model(); tick();
        drive(1'b1, 4'b0001, 1'b0); check_model(); tick();
        drive(1'b1, 4'b0001, 1'b0); check_model();
        chk("hs.full_gnt", gnt, 4'b0000);
        chk("hs.full_lock", dbg_state, 1'b1);
        chk("hs.full_count", count, 4);
        tick();
        drive(1'b1, 4'b0011, 1'b0); check_model(); chk("hs.stall_gnt", gnt, 4'b0000); tick();
        drive(1'b1, 4'b0011, 1'b1); check_model(); chk("hs.full_pop_gnt", gnt, 4'b0000); tick();
        drive(1'b1, 4'b0011, 1'b0); check_model(); chk("hs.resume_gnt", gnt, 4'b0001); tick();
        drive(1'b1, 4'b0011, 1'b1); check_model(); tick();
        drive(1'b1, 4'b0011, 1'b0); check_model(); chk("hs.next_owner_gnt", gnt, 4'b0010); tick();

        // Randomized traffic: requests are held until granted, occasional mid-run resets.
        drive(1'b0, '0, 1'b0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            r_rst = ($urandom_range(0, 299) != 0);
            nr    = req;
            for (int i = 0; i < NREQ; i++) begin
                if (!nr[i] || last_g == i) begin
                    nr[i] = (last_g == i) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
                    if (nr[i]) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            r_pop = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive(r_rst, nr, r_pop);
            check_model();
            tick();
        end

`ifdef FIFO_ARB_GRANT_CNT_EN
        drive(1'b0, '0, 1'b0);
        tick();
        chk("gnt_cnt_reset", gnt_cnt, 32'd0);
        for (int c = 0; c < 300; c++) begin
            drive(1'b1, 4'b0001, 1'b1);
            check_model();
            tick();
            if (c == 99) chk("gnt_cnt_100", gnt_cnt, {24'd0, 8'd100});
        end
        chk("gnt_cnt_sat", gnt_cnt, {24'd0, 8'd255});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
